// File: rtl/branch_predictor_btb.sv
// Branch target buffer with per-entry saturating direction counters.
// Fetch looks up pc_i combinationally; the resolving stage writes outcomes back,
// gets a mispredict flag plus a redirect PC, and a pair of saturating
// performance counters track resolved branches and mispredictions.
module branch_predictor_btb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 4,
    parameter int unsigned CTR_W  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              flush_all_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_pred_taken_i,
    input  logic [ADDR_W-1:0] upd_pred_target_i,
    output logic              mispredict_o,
    output logic [ADDR_W-1:0] correct_pc_o,
    output logic [CNT_W-1:0]  branch_cnt_o,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    // Weakly not-taken on reset, weakly taken on allocation.
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CTR_W-1:0]  ctr_q    [ENTRIES];

    logic [CNT_W-1:0]  branch_cnt_q;
    logic [CNT_W-1:0]  mispred_cnt_q;

    logic [IDX_W-1:0]  rd_idx;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_hit;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;
    logic [CTR_W-1:0]  ctr_nxt;
    logic              upd_en;

    // Byte-offset bits never select an entry.
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^{pc_i[1:0], upd_pc_i[1:0]};

    assign upd_en = start_i & upd_valid_i;

    // Lookup path: read-before-write, no bypass of a same-cycle update.
    always_comb begin
        rd_idx        = pc_i[IDX_W+1:2];
        rd_tag        = pc_i[ADDR_W-1:IDX_W+2];
        rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        pred_taken_o  = start_i & rd_hit & ctr_q[rd_idx][CTR_W-1];
        pred_target_o = pred_taken_o ? target_q[rd_idx] : pc_i + PC_STEP;
    end

    // Resolution path: mispredict flag, redirect PC and the next counter value.
    always_comb begin
        mispredict_o = upd_valid_i &
                       ((upd_taken_i != upd_pred_taken_i) |
                        (upd_taken_i & (upd_pred_target_i != upd_target_i)));
        correct_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + PC_STEP;
        upd_idx      = upd_pc_i[IDX_W+1:2];
        upd_tag      = upd_pc_i[ADDR_W-1:IDX_W+2];
        upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ctr_nxt      = ctr_q[upd_idx];
        if (upd_taken_i) begin
            if (ctr_q[upd_idx] != CTR_MAX) ctr_nxt = ctr_q[upd_idx] + CTR_W'(1);
        end else begin
            if (ctr_q[upd_idx] != '0) ctr_nxt = ctr_q[upd_idx] - CTR_W'(1);
        end
    end

    // Table state: flush wins over a simultaneous update; counters survive a flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (start_i) begin
            if (flush_all_i) begin
                for (int i = 0; i < int'(ENTRIES); i++) begin
                    valid_q[i] <= 1'b0;
                end
            end else if (upd_valid_i) begin
                if (upd_hit) begin
                    ctr_q[upd_idx] <= ctr_nxt;
                    if (upd_taken_i) target_q[upd_idx] <= upd_target_i;
                end else if (upd_taken_i) begin
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= upd_target_i;
                    ctr_q[upd_idx]    <= CTR_WT;
                end
            end
        end
    end

    // Saturating performance counters, independent of flush.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_en) begin
            if (branch_cnt_q != {CNT_W{1'b1}}) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict_o && (mispred_cnt_q != {CNT_W{1'b1}})) begin
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: the driver issues one vector per
// cycle and queues its hand-computed response; a monitor compares at negedge.
module tb_branch_predictor_btb;

    localparam int unsigned CNT_W = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        flush_all_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic        upd_pred_taken_i = 1'b0;
    logic [31:0] upd_pred_target_i = '0;
    logic        mispredict_o;
    logic [31:0] correct_pc_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    branch_predictor_btb #(
        .ADDR_W(32),
        .IDX_W (4),
        .CTR_W (2),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .flush_all_i      (flush_all_i),
        .pc_i             (pc_i),
        .pred_taken_o     (pred_taken_o),
        .pred_target_o    (pred_target_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_taken_i      (upd_taken_i),
        .upd_target_i     (upd_target_i),
        .upd_pred_taken_i (upd_pred_taken_i),
        .upd_pred_target_i(upd_pred_target_i),
        .mispredict_o     (mispredict_o),
        .correct_pc_o     (correct_pc_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string       name;
        logic        ptk;
        logic [31:0] ptg;
        logic        mis;
        logic [31:0] cpc;
        logic [7:0]  bc;
        logic [7:0]  mc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got 0x%08h, want 0x%08h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so every queued entry is due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pred_taken", {31'b0, pred_taken_o}, {31'b0, e.ptk});
                chk(e.name, "pred_target", pred_target_o, e.ptg);
                chk(e.name, "mispredict", {31'b0, mispredict_o}, {31'b0, e.mis});
                chk(e.name, "correct_pc", correct_pc_o, e.cpc);
                chk(e.name, "branch_cnt", {24'b0, branch_cnt_o}, {24'b0, e.bc});
                chk(e.name, "mispred_cnt", {24'b0, mispred_cnt_o}, {24'b0, e.mc});
            end
        end
    end

    task automatic cyc(input logic st, input logic fl, input logic [31:0] pc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic upt, input logic [31:0] uptg);
        @(posedge clk_i);
        #1;
        start_i           = st;
        flush_all_i       = fl;
        pc_i              = pc;
        upd_valid_i       = uv;
        upd_pc_i          = upc;
        upd_taken_i       = ut;
        upd_target_i      = utg;
        upd_pred_taken_i  = upt;
        upd_pred_target_i = uptg;
    endtask

    task automatic want(input string nm, input logic ptk, input logic [31:0] ptg,
                        input logic mis, input logic [31:0] cpc, input logic [7:0] bc,
                        input logic [7:0] mc);
        exp_t e;
        e.name = nm; e.ptk = ptk; e.ptg = ptg; e.mis = mis; e.cpc = cpc;
        e.bc = bc; e.mc = mc;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset held low.
        cyc(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        want("reset", 0, 32'h44, 0, 32'h4, 0, 0);
        @(posedge clk_i); #1; rst_i = 1'b1;

        // Allocate 0x40 -> 0x100.
        cyc(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
        want("alloc", 0, 32'h44, 1, 32'h100, 0, 0);
        cyc(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        want("hit_after_alloc", 1, 32'h100, 0, 32'h4, 1, 1);
        // Three not-taken updates: ctr 2 -> 1 -> 0 -> 0.
        cyc(1, 0, 32'h40, 1, 32'h40, 0, 0, 1, 32'h100);
        want("nt1", 1, 32'h100, 1, 32'h44, 1, 1);
        cyc(1, 0, 32'h40, 1, 32'h40, 0, 0, 0, 0);
        want("nt2", 0, 32'h44, 0, 32'h44, 2, 2);
        cyc(1, 0, 32'h40, 1, 32'h40, 0, 0, 0, 0);
        want("nt3", 0, 32'h44, 0, 32'h44, 3, 2);
        // Saturated at 0: one taken brings it to 1, still not taken.
        cyc(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
        want("sat_lo_inc", 0, 32'h44, 1, 32'h100, 4, 2);
        cyc(1, 0, 32'h40, 1, 32'h40, 1, 32'h140, 0, 0);
        want("ctr1_retarget", 0, 32'h44, 1, 32'h140, 5, 3);
        // ctr 2, target 0x140; wrong predicted target counts as mispredict.
        cyc(1, 0, 32'h40, 1, 32'h40, 1, 32'h140, 1, 32'h100);
        want("tgt_mismatch", 1, 32'h140, 1, 32'h140, 6, 4);
        cyc(1, 0, 32'h40, 1, 32'h40, 1, 32'h140, 1, 32'h140);
        want("correct_taken", 1, 32'h140, 0, 32'h140, 7, 5);
        // ctr saturated at 3; a not-taken drops it to 2, still taken.
        cyc(1, 0, 32'h40, 1, 32'h40, 0, 0, 1, 32'h140);
        want("sat_hi_dec", 1, 32'h140, 1, 32'h44, 8, 5);
        // Alias 0x80 onto index 0.
        cyc(1, 0, 32'h40, 1, 32'h80, 1, 32'h200, 0, 0);
        want("alias_alloc", 1, 32'h140, 1, 32'h200, 9, 6);
        cyc(1, 0, 32'h40, 1, 32'hC0, 0, 0, 0, 0);
        want("alias_evicted", 0, 32'h44, 0, 32'hC4, 10, 7);
        cyc(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
        want("alias_hit", 1, 32'h200, 0, 32'h4, 11, 7);
        cyc(1, 0, 32'hC0, 0, 0, 0, 0, 0, 0);
        want("nt_miss_no_alloc", 0, 32'hC4, 0, 32'h4, 11, 7);
        // Same-cycle update and lookup returns old data.
        cyc(1, 0, 32'h80, 1, 32'h80, 1, 32'h300, 1, 32'h200);
        want("rbw_old", 1, 32'h200, 1, 32'h300, 11, 7);
        cyc(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
        want("rbw_new", 1, 32'h300, 0, 32'h4, 12, 8);
        // Flush with a simultaneous allocating update at index 1.
        cyc(1, 1, 32'h80, 1, 32'h44, 1, 32'h500, 0, 0);
        want("flush_cycle", 1, 32'h300, 1, 32'h500, 12, 8);
        cyc(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
        want("flushed_80", 0, 32'h84, 0, 32'h4, 13, 9);
        cyc(1, 0, 32'h44, 0, 0, 0, 0, 0, 0);
        want("flush_drop_upd", 0, 32'h48, 0, 32'h4, 13, 9);
        // PC+4 wraps.
        cyc(1, 0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        want("wrap", 0, 32'h0, 0, 32'h0, 13, 9);
        // start_i gating.
        cyc(1, 0, 32'h80, 1, 32'h80, 1, 32'h200, 0, 0);
        want("realloc", 0, 32'h84, 1, 32'h200, 14, 9);
        cyc(0, 0, 32'h80, 1, 32'h80, 0, 0, 1, 32'h200);
        want("stop_upd", 0, 32'h84, 1, 32'h84, 15, 10);
        cyc(0, 1, 32'h80, 0, 0, 0, 0, 0, 0);
        want("stop_flush", 0, 32'h84, 0, 32'h4, 15, 10);
        cyc(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
        want("stop_held", 1, 32'h200, 0, 32'h4, 15, 10);
        // Asynchronous reset mid-cycle; sampled before the next rising edge.
        cyc(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
        #1 rst_i = 1'b0;
        want("async_rst", 0, 32'h84, 0, 32'h4, 0, 0);
        @(posedge clk_i); #1; rst_i = 1'b1;
        cyc(1, 0, 32'h80, 0, 0, 0, 0, 0, 0);
        want("post_rst", 0, 32'h84, 0, 32'h4, 0, 0);
        // Drive 2**CNT_W-1 mispredicted updates, then more: counters hold.
        for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
            cyc(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
        end
        cyc(1, 0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
        want("cnt_full", 1, 32'h100, 1, 32'h100, 8'hFF, 8'hFF);
        cyc(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
        want("cnt_sat", 1, 32'h100, 0, 32'h4, 8'hFF, 8'hFF);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
